count_display_scanner: RTL and testbench
========================================

// Module: count_display_scanner
// PURPOSE
// Downstream stage of the 4-bit state counter: captures the counter's q value on each
// sample strobe into a 4-deep digit history and time-multiplexes it onto a 4-digit
// common-enable 7-segment display. Newest value on digit 0, oldest on digit 3.
// Also flags value changes so the debug/LED logic can count counter steps.
// PARAMETERS
// REFRESH_DIV  4  clock cycles each digit stays enabled (>=1; small for sim, large on board)
// BLANK_EMPTY  1  1: digits never written since reset are dark; 0: they show '0'
// PORTS
// clock    in   1  single system clock, rising edge
// clear    in   1  asynchronous reset, active-high
// value    in   4  counter state to capture (counter q[3:0])
// sample   in   1  capture strobe, sampled on clock edge
// seg      out  7  segments {g,f,e,d,c,b,a}, active-high, registered
// an       out  4  digit enable, one-hot, active-high, registered
// dp       out  1  decimal point, marks the newest digit, registered
// filled   out  3  number of captured digits, 0..4, saturating
// changed  out  1  one-cycle pulse: captured value differed from previous newest
// BEHAVIOUR
// - Reset (clear=1, async, takes effect immediately): hist[0..3]=0, valid=4'b0000,
//   filled=0, prescaler=0, scan=0, an=4'b0001, seg=7'h00, dp=0, changed=0.
// - Capture, on edge with sample=1: hist[3]<=hist[2], hist[2]<=hist[1], hist[1]<=hist[0],
//   hist[0]<=value; valid<={valid[2:0],1}; filled<=min(filled+1,4).
//   changed<=1 if filled==0 or value!=hist[0], else 0. Edge with sample=0: changed<=0.
//   Back-to-back samples every cycle are legal; each edge captures one value.
// - Scan: prescaler counts 0..REFRESH_DIV-1; at REFRESH_DIV-1 it returns to 0 and
//   scan (2 bits) increments, wrapping 3->0. REFRESH_DIV=1: scan advances every edge.
// - Output register, every edge: an<=onehot(scan), seg<=hex7(hist[scan]),
//   dp<=(scan==0)&valid[0]. Outputs reflect pre-edge scan/hist: 1-cycle latency
//   from capture or scan change to seg/an.
// - Blanking: BLANK_EMPTY=1 and valid[scan]==0 -> seg<=0, dp<=0.
// - hex7 table (seg hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F
//   A=77 b=7C C=39 d=5E E=79 F=71. All 16 codes legal (counter sequence is arbitrary).
// - Simultaneous capture and scan step on one edge: both happen; no priority needed.
// - clear mid-scan or mid-capture: all state drops to reset values at once; first
//   sample after release captures into digit 0 with changed=1.
// - an is always exactly one-hot, including reset; no all-off cycles.
// STRUCTURE
// - Shared package/include: hex7 segment constants, REFRESH width as clog2(REFRESH_DIV).
// - Sub-module hex_to_seg7 (4-bit in, 7-bit out, combinational) for the decoder;
//   history shift, prescaler, scan counter and output register live in this module.
// TESTING (REFRESH_DIV=4 unless stated)
// 1 Assert clear mid-run between edges -> an=0001, seg=00, dp=0, filled=0, changed=0
//   immediately, before the next clock edge.
// 2 After reset, one sample value=5 -> next edge filled=1, changed=1 for exactly one
//   cycle; while an=0001 seg=6D, dp=1; an=0010/0100/1000 show seg=00.
// 3 Samples 1,2,3,4,9 on consecutive edges -> filled saturates at 4; digits 0..3 show
//   6F,66,4F,5B; no sample -> an steps 0001,0010,0100,1000 each held 4 cycles, wraps.
// 4 Sample 9 again after test 3 -> changed stays 0; history shifts to 9,9,4,3.
// 5 REFRESH_DIV=1 -> an rotates every cycle; sample coinciding with scan step shows new
//   digit one cycle later on its enable slot, no glitch or double-enable.
// 6 BLANK_EMPTY=0, reset then one sample value=A -> digit 0 seg=77, digits 1..3 seg=3F.

Source files
------------

// File: rtl/count_display_scanner_pkg.sv
// count_display_scanner_pkg
// Shared definitions for the count display scanner slice:
//   - nibble_t       : one captured counter value / one display digit
//   - SEG_BLANK      : segment pattern for a dark digit
//   - HEX7_TABLE     : hex digit to 7-segment pattern, bit order {g,f,e,d,c,b,a}
//   - refresh_width  : prescaler width for a given refresh divider (never below 1 bit)
//   - scan_onehot    : digit index to one-hot digit enable
package count_display_scanner_pkg;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_BLANK = 7'h00;

  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  // $clog2(1) is 0, which would give a zero-width prescaler, so floor at 1 bit.
  function automatic int refresh_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  function automatic logic [3:0] scan_onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

endpackage

// File: rtl/count_display_scanner_hex_to_seg7.sv
// hex_to_seg7
// Combinational hex to 7-segment decoder (active-high segments).
// Ports:
//   hex  in  4  digit value 0..F
//   seg  out 7  segments {g,f,e,d,c,b,a}
module hex_to_seg7
  import count_display_scanner_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  always_comb begin
    seg = HEX7_TABLE[hex];
  end

endmodule

// File: rtl/count_display_scanner.sv
// count_display_scanner
// Captures the state counter's value on each sample strobe into a 4-deep history
// (newest on digit 0) and time-multiplexes the history onto a 4-digit
// common-enable 7-segment display. Also pulses 'changed' when a captured value
// differs from the previous newest value.
// Parameters:
//   REFRESH_DIV  clock cycles each digit stays enabled (>= 1)
//   BLANK_EMPTY  1: never-written digits are dark, 0: they show '0'
// Ports:
//   clock    in   1  system clock, rising edge
//   clear    in   1  asynchronous reset, active-high
//   value    in   4  counter value to capture
//   sample   in   1  capture strobe
//   seg      out  7  segments {g,f,e,d,c,b,a}, registered
//   an       out  4  one-hot digit enable, registered
//   dp       out  1  decimal point on the newest digit, registered
//   filled   out  3  number of captured digits, saturates at 4
//   changed  out  1  one-cycle pulse on a capture that changed the newest value
module count_display_scanner
  import count_display_scanner_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter int BLANK_EMPTY = 1
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] value,
  input  logic       sample,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp,
  output logic [2:0] filled,
  output logic       changed
);

  localparam int PW = refresh_width(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

  nibble_t       hist [4];
  logic [3:0]    valid;
  logic [PW-1:0] prescaler;
  logic [1:0]    scan;

  nibble_t    shown_digit;
  logic [6:0] decoded;
  logic       digit_live;

  assign shown_digit = hist[scan];
  assign digit_live  = valid[scan];

  hex_to_seg7 u_hex_to_seg7 (
    .hex (shown_digit),
    .seg (decoded)
  );

  // History shift register. 'changed' compares against the pre-shift newest
  // digit; an empty history always counts as a change.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 4; i++) hist[i] <= '0;
      valid   <= 4'b0000;
      filled  <= 3'd0;
      changed <= 1'b0;
    end else if (sample) begin
      hist[3] <= hist[2];
      hist[2] <= hist[1];
      hist[1] <= hist[0];
      hist[0] <= value;
      valid   <= {valid[2:0], 1'b1};
      if (filled != 3'd4) filled <= filled + 3'd1;
      changed <= (filled == 3'd0) || (value != hist[0]);
    end else begin
      changed <= 1'b0;
    end
  end

  // Refresh prescaler and digit scan counter; scan wraps naturally at 2 bits.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      prescaler <= '0;
      scan      <= 2'd0;
    end else if (prescaler == PRESC_LAST) begin
      prescaler <= '0;
      scan      <= scan + 2'd1;
    end else begin
      prescaler <= prescaler + PW'(1);
    end
  end

  // Display output register, driven from the pre-edge scan and history so the
  // enable and its segment pattern always change together.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      an  <= 4'b0001;
      seg <= SEG_BLANK;
      dp  <= 1'b0;
    end else begin
      an <= scan_onehot(scan);
      if ((BLANK_EMPTY != 0) && !digit_live) begin
        seg <= SEG_BLANK;
        dp  <= 1'b0;
      end else begin
        seg <= decoded;
        dp  <= (scan == 2'd0) && valid[0];
      end
    end
  end

endmodule

// File: tb/tb_count_display_scanner.sv
// tb_count_display_scanner
// Drives three scanner instances with identical stimulus:
//   inst 0: REFRESH_DIV=4, BLANK_EMPTY=1
//   inst 1: REFRESH_DIV=1, BLANK_EMPTY=1
//   inst 2: REFRESH_DIV=4, BLANK_EMPTY=0
// A reference model holds the captured values as a newest-first list and the
// number of edges since reset, and derives every expected output from those.
module tb_count_display_scanner;

  localparam int NI = 3;
  localparam int DIV_CFG   [NI] = '{4, 1, 4};
  localparam int BLANK_CFG [NI] = '{1, 1, 0};
  localparam logic [6:0] HEX_REF [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  logic       clock;
  logic       clear;
  logic [3:0] value;
  logic       sample;

  logic [6:0] seg_o     [NI];
  logic [3:0] an_o      [NI];
  logic       dp_o      [NI];
  logic [2:0] filled_o  [NI];
  logic       changed_o [NI];

  int check_count;
  int pass_count;

  // reference model state
  logic [3:0] hq [$];
  int         edges;

  logic [6:0] exp_seg [NI];
  logic [3:0] exp_an  [NI];
  logic       exp_dp  [NI];
  logic [2:0] exp_filled;
  logic       exp_changed;

  count_display_scanner #(.REFRESH_DIV(4), .BLANK_EMPTY(1)) dut0 (
    .clock(clock), .clear(clear), .value(value), .sample(sample),
    .seg(seg_o[0]), .an(an_o[0]), .dp(dp_o[0]),
    .filled(filled_o[0]), .changed(changed_o[0])
  );

  count_display_scanner #(.REFRESH_DIV(1), .BLANK_EMPTY(1)) dut1 (
    .clock(clock), .clear(clear), .value(value), .sample(sample),
    .seg(seg_o[1]), .an(an_o[1]), .dp(dp_o[1]),
    .filled(filled_o[1]), .changed(changed_o[1])
  );

  count_display_scanner #(.REFRESH_DIV(4), .BLANK_EMPTY(0)) dut2 (
    .clock(clock), .clear(clear), .value(value), .sample(sample),
    .seg(seg_o[2]), .an(an_o[2]), .dp(dp_o[2]),
    .filled(filled_o[2]), .changed(changed_o[2])
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    check_count++;
    if (observed === expected) pass_count++;
    else $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, observed, expected, $time);
  endtask

  task automatic model_reset();
    hq.delete();
    edges = 0;
  endtask

  // Advance the model by one clock edge with the given inputs.
  task automatic model_edge(input logic s, input logic [3:0] v);
    for (int i = 0; i < NI; i++) begin
      int sc;
      sc = (edges / DIV_CFG[i]) % 4;
      exp_an[i] = 4'(1 << sc);
      if (sc < hq.size()) begin
        exp_seg[i] = HEX_REF[hq[sc]];
        exp_dp[i]  = (sc == 0);
      end else begin
        exp_seg[i] = (BLANK_CFG[i] != 0) ? 7'h00 : HEX_REF[0];
        exp_dp[i]  = 1'b0;
      end
    end
    exp_changed = s && ((hq.size() == 0) || (v != hq[0]));
    if (s) begin
      hq.push_front(v);
      if (hq.size() > 4) void'(hq.pop_back());
    end
    exp_filled = 3'(hq.size());
    edges++;
  endtask

  task automatic compare_all();
    for (int i = 0; i < NI; i++) begin
      check_output($sformatf("seg[%0d]", i), 32'(seg_o[i]), 32'(exp_seg[i]));
      check_output($sformatf("an[%0d]", i), 32'(an_o[i]), 32'(exp_an[i]));
      check_output($sformatf("dp[%0d]", i), 32'(dp_o[i]), 32'(exp_dp[i]));
      check_output($sformatf("filled[%0d]", i), 32'(filled_o[i]), 32'(exp_filled));
      check_output($sformatf("changed[%0d]", i), 32'(changed_o[i]), 32'(exp_changed));
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < NI; i++) begin
      check_output($sformatf("%s_an[%0d]", tag, i), 32'(an_o[i]), 32'h1);
      check_output($sformatf("%s_seg[%0d]", tag, i), 32'(seg_o[i]), 32'h0);
      check_output($sformatf("%s_dp[%0d]", tag, i), 32'(dp_o[i]), 32'h0);
      check_output($sformatf("%s_filled[%0d]", tag, i), 32'(filled_o[i]), 32'h0);
      check_output($sformatf("%s_changed[%0d]", tag, i), 32'(changed_o[i]), 32'h0);
    end
  endtask

  // One clock edge with the current inputs, checked 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    model_edge(sample, value);
    #1;
    compare_all();
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic apply_stimulus(input logic s, input logic [3:0] v);
    sample = s;
    value  = v;
    step();
    @(negedge clock);
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, 4'h0);
  endtask

  // Asserts clear between edges, checks the immediate effect, holds it over
  // an edge, then releases at a negedge.
  task automatic do_clear();
    sample = 1'b0;
    step();
    #2;
    clear = 1'b1;
    #1;
    check_reset_state("clr_async");
    @(posedge clock);
    #1;
    check_reset_state("clr_held");
    @(negedge clock);
    clear = 1'b0;
    model_reset();
  endtask

  initial begin
    check_count = 0;
    pass_count  = 0;
    clear  = 1'b1;
    sample = 1'b0;
    value  = 4'h0;
    model_reset();
    #1;
    check_reset_state("por");
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;

    // single capture, then watch every digit slot for a full rotation
    apply_stimulus(1'b1, 4'h5);
    idle(18);

    // consecutive captures saturating the history
    apply_stimulus(1'b1, 4'h1);
    apply_stimulus(1'b1, 4'h2);
    apply_stimulus(1'b1, 4'h3);
    apply_stimulus(1'b1, 4'h4);
    apply_stimulus(1'b1, 4'h9);
    idle(20);

    // repeated value: no change pulse
    apply_stimulus(1'b1, 4'h9);
    idle(18);

    // clear mid-run, then capture A into an empty display
    idle(5);
    do_clear();
    apply_stimulus(1'b1, 4'hA);
    idle(18);

    // randomized run with occasional clears and repeated values
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_clear();
      end else begin
        logic [3:0] v;
        if (hq.size() > 0 && $urandom_range(0, 3) == 0) v = hq[0];
        else v = 4'($urandom_range(0, 15));
        apply_stimulus(1'($urandom_range(0, 2) == 0), v);
      end
    end

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
